// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition encodings,
// NZCV bit positions and the flag-group mask helper.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ  = 4'b0000,
        COND_NE  = 4'b0001,
        COND_CS  = 4'b0010,
        COND_CC  = 4'b0011,
        COND_MI  = 4'b0100,
        COND_PL  = 4'b0101,
        COND_VS  = 4'b0110,
        COND_VC  = 4'b0111,
        COND_HI  = 4'b1000,
        COND_LS  = 4'b1001,
        COND_GE  = 4'b1010,
        COND_LT  = 4'b1011,
        COND_GT  = 4'b1100,
        COND_LE  = 4'b1101,
        COND_AL  = 4'b1110,
        COND_UNC = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bits of NZCV owned by group g when the register is split into 'groups' slices.
    function automatic logic [3:0] group_mask(input int groups, input int g);
        logic [3:0] m;
        int         w;
        w = 4 / groups;
        m = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if ((b >= w * g) && (b < w * (g + 1))) begin
                m[b] = 1'b1;
            end else begin
                m[b] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/condeval.sv
// Combinational ARM condition evaluator (Cond + NZCV -> CondEx); code 1111 is
// treated as unconditional.
module condeval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n_s, z_s, c_s, v_s;

    assign n_s = flags_i[FLAG_N];
    assign z_s = flags_i[FLAG_Z];
    assign c_s = flags_i[FLAG_C];
    assign v_s = flags_i[FLAG_V];

    // Decode the condition field against the current flags.
    always_comb begin
        cond_ex_o = 1'b1;
        case (cond_e'(cond_i))
            COND_EQ:  cond_ex_o = z_s;
            COND_NE:  cond_ex_o = ~z_s;
            COND_CS:  cond_ex_o = c_s;
            COND_CC:  cond_ex_o = ~c_s;
            COND_MI:  cond_ex_o = n_s;
            COND_PL:  cond_ex_o = ~n_s;
            COND_VS:  cond_ex_o = v_s;
            COND_VC:  cond_ex_o = ~v_s;
            COND_HI:  cond_ex_o = c_s & ~z_s;
            COND_LS:  cond_ex_o = ~c_s | z_s;
            COND_GE:  cond_ex_o = ~(n_s ^ v_s);
            COND_LT:  cond_ex_o = n_s ^ v_s;
            COND_GT:  cond_ex_o = ~z_s & ~(n_s ^ v_s);
            COND_LE:  cond_ex_o = z_s | (n_s ^ v_s);
            COND_AL:  cond_ex_o = 1'b1;
            COND_UNC: cond_ex_o = 1'b1;
            default:  cond_ex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/condlogic_stk.sv
// Conditional-execution unit: NZCV register with grouped writes, latched CondEx,
// gated write enables and an optional shadow-flag stack (CONDLOGIC_SHADOW_STACK_EN).
module condlogic_stk
    import cond_pkg::*;
#(
    parameter int FLAG_GROUPS  = 2,
    parameter int SHADOW_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [3:0]                          Cond,
    input  logic [3:0]                          ALUFlags,
    input  logic [FLAG_GROUPS-1:0]              FlagW,
    input  logic                                CondLatch,
    input  logic                                PCS,
    input  logic                                NextPC,
    input  logic                                RegW,
    input  logic                                MemW,
    input  logic                                FlagPush,
    input  logic                                FlagPop,
    input  logic                                ErrClr,
    output logic                                PCWrite,
    output logic                                RegWrite,
    output logic                                MemWrite,
    output logic                                CondExQ,
    output logic [3:0]                          Flags,
    output logic [$clog2(SHADOW_DEPTH+1)-1:0]   StackLevel,
    output logic                                StackFull,
    output logic                                StackEmpty,
    output logic                                StackErr
);

    localparam int LW = $clog2(SHADOW_DEPTH + 1);

    logic       cond_ex_s;
    logic [3:0] flags_q, flags_d;
    logic [3:0] upd_mask_s;
    logic       cexq_q, cexq_d;
    logic       pop_ok_s;
    logic [3:0] pop_val_s;

    condeval u_condeval (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex_s)
    );

    // Flag next-state: a successful pop overrides any group write.
    always_comb begin
        upd_mask_s = 4'b0000;
        for (int g = 0; g < FLAG_GROUPS; g++) begin
            if (FlagW[g] && cond_ex_s) begin
                upd_mask_s = upd_mask_s | group_mask(FLAG_GROUPS, g);
            end else begin
                upd_mask_s = upd_mask_s;
            end
        end
        if (pop_ok_s) begin
            flags_d = pop_val_s;
        end else begin
            flags_d = (flags_q & ~upd_mask_s) | (ALUFlags & upd_mask_s);
        end
        if (CondLatch) begin
            cexq_d = cond_ex_s;
        end else begin
            cexq_d = cexq_q;
        end
    end

    // Architectural flag and condition registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
            cexq_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cexq_q  <= cexq_d;
        end
    end

    assign Flags    = flags_q;
    assign CondExQ  = cexq_q;
    assign RegWrite = RegW & cexq_q;
    assign MemWrite = MemW & cexq_q;
    assign PCWrite  = (PCS & cexq_q) | NextPC;

`ifdef CONDLOGIC_SHADOW_STACK_EN
    logic [3:0]    stack_q [SHADOW_DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;
    logic          full_s, empty_s;
    logic          push_req_s, pop_req_s, push_ok_s, err_ev_s;

    assign full_s     = (level_q == LW'(SHADOW_DEPTH));
    assign empty_s    = (level_q == LW'(0));
    assign push_req_s = FlagPush & ~FlagPop;
    assign pop_req_s  = FlagPop & ~FlagPush;
    assign push_ok_s  = push_req_s & ~full_s;
    assign pop_ok_s   = pop_req_s & ~empty_s;
    assign err_ev_s   = (push_req_s & full_s) | (pop_req_s & empty_s) | (FlagPush & FlagPop);

    // Top-of-stack read mux and level / sticky-error next state.
    always_comb begin
        pop_val_s = 4'b0000;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                pop_val_s = stack_q[i];
            end else begin
                pop_val_s = pop_val_s;
            end
        end
        if (push_ok_s) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
        err_d = err_ev_s | (err_q & ~ErrClr);
    end

    // Stack storage, level counter and sticky error register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                stack_q[i] <= 4'b0000;
            end
            level_q <= LW'(0);
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                if (push_ok_s && (level_q == LW'(i))) begin
                    stack_q[i] <= flags_q;
                end else begin
                    stack_q[i] <= stack_q[i];
                end
            end
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    assign StackLevel = level_q;
    assign StackFull  = full_s;
    assign StackEmpty = empty_s;
    assign StackErr   = err_q;
`else
    logic unused_stack_s;

    assign unused_stack_s = ^{FlagPush, FlagPop, ErrClr};
    assign pop_ok_s       = 1'b0;
    assign pop_val_s      = 4'b0000;
    assign StackLevel     = LW'(0);
    assign StackFull      = 1'b0;
    assign StackEmpty     = 1'b1;
    assign StackErr       = 1'b0;
`endif

endmodule

// File: tb/tb_condlogic_stk.sv
// Scoreboard bench for condlogic_stk: stimulus pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares.
module tb_condlogic_stk;

    localparam int FG = 2;
    localparam int SD = 4;
    localparam int LW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    Cond, ALUFlags;
    logic [FG-1:0] FlagW;
    logic          CondLatch, PCS, NextPC, RegW, MemW, FlagPush, FlagPop, ErrClr;
    logic          PCWrite, RegWrite, MemWrite, CondExQ;
    logic [3:0]    Flags;
    logic [LW-1:0] StackLevel;
    logic          StackFull, StackEmpty, StackErr;

    condlogic_stk #(.FLAG_GROUPS(FG), .SHADOW_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .FlagPush(FlagPush), .FlagPop(FlagPop), .ErrClr(ErrClr),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondExQ(CondExQ),
        .Flags(Flags), .StackLevel(StackLevel), .StackFull(StackFull),
        .StackEmpty(StackEmpty), .StackErr(StackErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic       cexq;
        int         level;
        logic       full, empty, err, pcw, regw, memw;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_flags;
    logic       m_cexq;
    logic       m_err;
    logic [3:0] m_stack[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic bit ref_cond(input int c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic pcs, npc, rw, mw, input string tag);
        exp_t e;
        e.flags = m_flags;
        e.cexq  = m_cexq;
        e.level = m_stack.size();
        e.full  = (m_stack.size() == SD);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        e.pcw   = (pcs & m_cexq) | npc;
        e.regw  = rw & m_cexq;
        e.memw  = mw & m_cexq;
        e.tag   = tag;
        return e;
    endfunction

    task automatic chk(input string tag, input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, nm, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "Flags",      8'(Flags),      8'(e.flags));
                chk(e.tag, "CondExQ",    8'(CondExQ),    8'(e.cexq));
                chk(e.tag, "StackLevel", 8'(StackLevel), 8'(e.level));
                chk(e.tag, "StackFull",  8'(StackFull),  8'(e.full));
                chk(e.tag, "StackEmpty", 8'(StackEmpty), 8'(e.empty));
                chk(e.tag, "StackErr",   8'(StackErr),   8'(e.err));
                chk(e.tag, "PCWrite",    8'(PCWrite),    8'(e.pcw));
                chk(e.tag, "RegWrite",   8'(RegWrite),   8'(e.regw));
                chk(e.tag, "MemWrite",   8'(MemWrite),   8'(e.memw));
            end
        end
    end

    task automatic step(input logic [3:0] c, input logic [3:0] alu, input logic [FG-1:0] fw,
                        input logic lat, pcs, npc, rw, mw, psh, pop, clr, input string tag);
        logic [3:0] nf;
        bit         cex, ev;
        int         w;
        @(posedge clk);
        #1;
        reset = 1'b1; Cond = c; ALUFlags = alu; FlagW = fw; CondLatch = lat;
        PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
        FlagPush = psh; FlagPop = pop; ErrClr = clr;
        sb.push_back(mk_exp(pcs, npc, rw, mw, tag));
        cex = ref_cond(int'(c), m_flags);
        w   = 4 / FG;
        nf  = m_flags;
        for (int b = 0; b < 4; b++) begin
            if (fw[b / w] && cex) nf[b] = alu[b];
        end
        ev = 1'b0;
`ifdef CONDLOGIC_SHADOW_STACK_EN
        if (psh && pop) ev = 1'b1;
        else if (psh) begin
            if (m_stack.size() == SD) ev = 1'b1;
            else m_stack.push_back(m_flags);
        end else if (pop) begin
            if (m_stack.size() == 0) ev = 1'b1;
            else nf = m_stack.pop_back();
        end
        m_err = ev || (m_err && !clr);
`endif
        m_flags = nf;
        if (lat) m_cexq = cex;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b0; Cond = 4'd14; ALUFlags = 4'hF; FlagW = '1; CondLatch = 1'b1;
        PCS = 1'b1; NextPC = 1'($urandom_range(0, 1)); RegW = 1'b1; MemW = 1'b1;
        FlagPush = 1'b0; FlagPop = 1'b0; ErrClr = 1'b0;
        m_flags = 4'b0000; m_cexq = 1'b0; m_err = 1'b0; m_stack.delete();
        sb.push_back(mk_exp(PCS, NextPC, RegW, MemW, tag));
    endtask

    task automatic setf(input logic [3:0] v, input string tag);
        step(4'd14, v, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic stk(input logic psh, pop, clr, input string tag);
        step(4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, psh, pop, clr, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; Cond = 4'd0; ALUFlags = 4'd0; FlagW = '0; CondLatch = 1'b0;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
        FlagPush = 1'b0; FlagPop = 1'b0; ErrClr = 1'b0;
        m_flags = 4'b0000; m_cexq = 1'b0; m_err = 1'b0;
        do_reset("init");

        // Group writes: upper group only, then blocked by a failing NE.
        step(4'd14, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "grp_al");
        setf(4'b0100, "grp_setz");
        step(4'd1, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "grp_ne");
        stk(1'b0, 1'b0, 1'b0, "grp_hold");

        // EQ gating of RegWrite after CondLatch with Z=1 then Z=0.
        step(4'd0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "eq_z1");
        step(4'd0, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "eq_z1_w");
        step(4'd0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "eq_z0");
        step(4'd0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "eq_z0_w");

        // Nested push/pop.
        setf(4'b1000, "nest_f1");
        stk(1'b1, 1'b0, 1'b0, "nest_push1");
        setf(4'b0100, "nest_f2");
        stk(1'b1, 1'b0, 1'b0, "nest_push2");
        setf(4'b0011, "nest_f3");
        stk(1'b0, 1'b1, 1'b0, "nest_pop1");
        stk(1'b0, 1'b1, 1'b0, "nest_pop2");
        stk(1'b0, 1'b0, 1'b0, "nest_idle");

        // Overflow, clear, underflow, simultaneous push+pop.
        for (int i = 0; i < 5; i++) begin
            setf(4'(i + 1), "ovf_f");
            stk(1'b1, 1'b0, 1'b0, "ovf_push");
        end
        stk(1'b0, 1'b0, 1'b1, "ovf_clr");
        for (int i = 0; i < 5; i++) stk(1'b0, 1'b1, 1'b0, "unf_pop");
        stk(1'b0, 1'b0, 1'b1, "unf_clr");
        stk(1'b1, 1'b0, 1'b0, "both_pre");
        stk(1'b1, 1'b1, 1'b0, "both");
        stk(1'b1, 1'b1, 1'b1, "both_clr");
        stk(1'b0, 1'b0, 1'b0, "both_idle");

        // Collisions with flag writes.
        setf(4'b1001, "col_f");
        stk(1'b1, 1'b0, 1'b0, "col_push");
        step(4'd14, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "col_popw");
        step(4'd14, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "col_pushw");
        stk(1'b0, 1'b1, 1'b0, "col_pop");
        stk(1'b0, 1'b0, 1'b0, "col_idle");

        // Asynchronous reset mid-run with state held.
        setf(4'b1010, "rst_f");
        stk(1'b1, 1'b0, 1'b0, "rst_push1");
        stk(1'b1, 1'b0, 1'b0, "rst_push2");
        do_reset("rst_mid");
        stk(1'b0, 1'b0, 1'b0, "rst_after");

        // Condition sweep over all flag values.
        for (int f = 0; f < 16; f++) begin
            setf(4'(f), "sweep_f");
            for (int c = 0; c < 16; c++) begin
                step(4'(c), 4'(~f), 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sweep");
            end
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_rst");
            end else begin
                step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), FG'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 7) == 0), "rand");
            end
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
